// File: rtl/enc_bin2onehot_pipe_if.sv
// Handshake bundle for the binary-to-one-hot pipeline: producer side (in_*) and consumer side (out_*).
// The design takes the slave view; whoever drives codes and drains results takes the master view.
interface enc_bin2onehot_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 15
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out;
  logic              out_err;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_err
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_err
  );
endinterface

// File: rtl/enc_bin2onehot_pipe.sv
// Binary-to-one-hot encoder feeding a small FIFO output buffer with valid/ready on both sides.
// Codes at or above OUT_W encode to all zeros and are flagged per beat and in a sticky error bit.
module enc_bin2onehot_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 15,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  enc_bin2onehot_pipe_if.slave         bus,
  input  logic                         err_clr,
  output logic                         err_sticky,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [IN_W:0]  OUT_W_CODE = (IN_W+1)'(OUT_W);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [OUT_W-1:0] mem_oh  [DEPTH];
  logic             mem_err [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push;
  logic             pop;
  logic             out_valid;
  logic [OUT_W-1:0] enc_oh;
  logic             enc_err;

  // Ready and valid come straight from the occupancy register, so neither
  // side sees a combinational path from the other's handshake inputs.
  assign bus.in_ready  = (count < FULL_LVL);
  assign out_valid     = (count != '0);
  assign bus.out_valid = out_valid;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = out_valid && bus.out_ready;
  assign level         = count;

  always_comb begin
    enc_oh = '0;
    for (int i = 0; i < OUT_W; i++) begin
      enc_oh[i] = (bus.in == IN_W'(i));
    end
    enc_err = ({1'b0, bus.in} >= OUT_W_CODE);
  end

  // Storage needs no reset: an entry is only visible once count says it is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_oh[wr_ptr]  <= enc_oh;
      mem_err[wr_ptr] <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so an error pushed on a clearing edge is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (push && enc_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  assign bus.out     = out_valid ? mem_oh[rd_ptr]  : '0;
  assign bus.out_err = out_valid ? mem_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed self-checking bench for enc_bin2onehot_pipe at default parameters (IN_W=4, OUT_W=15, DEPTH=2).
module tb_enc_bin2onehot_pipe;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       err_sticky;
  logic [1:0] level;

  int checks;
  int errors;

  enc_bin2onehot_pipe_if #(.IN_W(4), .OUT_W(15)) bus ();

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] code, input logic rdy, input logic clr);
    bus.in_valid  = valid;
    bus.in        = code;
    bus.out_ready = rdy;
    err_clr       = clr;
  endtask

  // One clock step; inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out",       32'(bus.out),       32'd0);
    checkOutput("rst_out_err",   32'(bus.out_err),   32'd0);
    checkOutput("rst_level",     32'(level),         32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_sticky",    32'(err_sticky),    32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Basic encode: code 0 then code 14 (highest legal)
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("enc0_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("enc0_out",   32'(bus.out),       32'h0001);
    checkOutput("enc0_err",   32'(bus.out_err),   32'd0);
    checkOutput("enc0_level", 32'(level),         32'd1);
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0);
    tick();
    checkOutput("encE_out",   32'(bus.out),       32'h4000);
    checkOutput("encE_level", 32'(level),         32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_out",   32'(bus.out),       32'd0);

    // Out-of-range code 0xF
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    tick();
    checkOutput("oor_valid",  32'(bus.out_valid), 32'd1);
    checkOutput("oor_out",    32'(bus.out),       32'd0);
    checkOutput("oor_err",    32'(bus.out_err),   32'd1);
    checkOutput("oor_sticky", 32'(err_sticky),    32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("oor_pop_valid",  32'(bus.out_valid), 32'd0);
    checkOutput("oor_pop_err",    32'(bus.out_err),   32'd0);
    checkOutput("oor_pop_sticky", 32'(err_sticky),    32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    checkOutput("clr_sticky", 32'(err_sticky), 32'd0);

    // Backpressure: fill with 3 and 5, hold 7, then drain in order
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    tick();
    checkOutput("bp1_level", 32'(level),   32'd1);
    checkOutput("bp1_out",   32'(bus.out), 32'h0008);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    checkOutput("bp2_level",    32'(level),        32'd2);
    checkOutput("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp2_out",      32'(bus.out),      32'h0008);
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
    tick();
    checkOutput("bp3_level", 32'(level),   32'd2);
    checkOutput("bp3_out",   32'(bus.out), 32'h0008);
    tick();
    checkOutput("bp4_out",   32'(bus.out), 32'h0008);
    // Full with simultaneous pop: no push, level drops to 1
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
    tick();
    checkOutput("fullpop_level",    32'(level),        32'd1);
    checkOutput("fullpop_out",      32'(bus.out),      32'h0020);
    checkOutput("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("pushpop_level", 32'(level),   32'd1);
    checkOutput("pushpop_out",   32'(bus.out), 32'h0080);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("bp_empty_level", 32'(level), 32'd0);

    // Set/clear collision: set wins, then clear alone clears
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
    tick();
    checkOutput("coll_sticky", 32'(err_sticky),  32'd1);
    checkOutput("coll_err",    32'(bus.out_err), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("coll_clr_sticky", 32'(err_sticky), 32'd0);
    checkOutput("coll_clr_level",  32'(level),      32'd1);

    // Mid-operation reset with the buffer full and sticky set
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_level",  32'(level),      32'd2);
    checkOutput("pre_rst_sticky", 32'(err_sticky), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_out",      32'(bus.out),       32'd0);
    checkOutput("mid_rst_err",      32'(bus.out_err),   32'd0);
    checkOutput("mid_rst_level",    32'(level),         32'd0);
    checkOutput("mid_rst_sticky",   32'(err_sticky),    32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);

    // First push on the first rising edge after reset release
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b0);
    tick();
    checkOutput("post_rst_out",   32'(bus.out), 32'h0004);
    checkOutput("post_rst_level", 32'(level),   32'd1);
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
    tick();
    checkOutput("post_rst_out9",  32'(bus.out), 32'h0200);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("final_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_bin2onehot_pipe.md
ENC_BIN2ONEHOT_PIPE -- requirements
Module: enc_bin2onehot_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 4: binary code width.
REQ-002 SHALL have parameter OUT_W, default 15: one-hot width; legal range 1 <= OUT_W <= 2^IN_W.
REQ-003 SHALL have parameter DEPTH, default 2: output buffer entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat.
REQ-008 SHALL have port in  input  IN_W  binary code.
REQ-009 SHALL have port out_valid  output  1  output beat valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-011 SHALL have port out  output  OUT_W  one-hot result.
REQ-012 SHALL have port out_err  output  1  current output beat came from an out-of-range code.
REQ-013 SHALL have port err_sticky  output  1  an out-of-range code has been accepted since reset or clear.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of err_sticky.
REQ-015 SHALL have port level  output  clog2(DEPTH+1)  number of occupied buffer entries.

Function
REQ-016 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-017 in_ready SHALL be high iff level < DEPTH; it SHALL depend on registered state only, with no combinational path from out_ready or in_valid.
REQ-018 For an accepted code c < OUT_W, the stored entry SHALL be out with only bit c set and out_err 0.
REQ-019 For an accepted code c >= OUT_W, the stored entry SHALL be out all zeros and out_err 1.
REQ-020 Latency: a beat pushed into an empty buffer SHALL appear on out/out_valid at the next rising edge (1 cycle); there SHALL be no combinational input-to-output path.
REQ-021 Beats SHALL leave in acceptance order (FIFO); read and write pointers SHALL wrap modulo DEPTH.
REQ-022 out and out_err SHALL hold stable while out_valid && !out_ready.
REQ-023 While out_valid is 0, out SHALL be all zeros and out_err SHALL be 0.
REQ-024 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and keep order.
REQ-025 When level == DEPTH no push SHALL occur, even when a pop occurs in the same cycle; after that pop, in_ready SHALL be high on the following cycle.
REQ-026 A pop with level == 0 SHALL be impossible, since out_valid == (level != 0).
REQ-027 err_sticky SHALL set on the edge that pushes an out-of-range code.
REQ-028 err_sticky SHALL clear on an edge with err_clr high.
REQ-029 When set and clear coincide, set SHALL win.
REQ-030 level SHALL increment on push-only, decrement on pop-only, and otherwise hold.

Reset
REQ-031 Asserting rst low SHALL immediately, without waiting for clk: discard buffer contents, zero both pointers, level=0, out_valid=0, out=0, out_err=0, err_sticky=0.
REQ-032 During and after reset, in_ready SHALL be 1, including when reset is applied mid-operation with the buffer full.
REQ-033 The first push SHALL be possible on the first rising edge after rst deasserts.

Verification (defaults IN_W=4, OUT_W=15, DEPTH=2)
REQ-034 Basic encode: reset, then push in=0x0 with out_ready=1 -> next cycle out_valid=1, out=15'h0001, out_err=0; then push in=0xE -> out=15'h4000.
REQ-035 Out-of-range code: push in=0xF -> next cycle out=15'h0000, out_err=1, err_sticky=1; err_sticky stays 1 after the beat pops.
REQ-036 Backpressure: out_ready=0; push 3 then 5 -> level=2, in_ready=0; third beat in=7 is held with out=15'h0008 stable; raise out_ready -> outputs in order 15'h0008, 15'h0020, 15'h0080, and in_ready is high the cycle after the first pop.
REQ-037 Full with simultaneous pop: level=2, in_valid=1, out_ready=1 -> no push that cycle, level=1 next cycle.
REQ-038 Set/clear collision: err_clr=1 on the same edge an out-of-range code (0xF) is pushed -> err_sticky=1; err_clr=1 alone -> err_sticky=0.
REQ-039 Mid-operation reset: level=2, assert rst=0 between edges -> out_valid=0, out=0, level=0, err_sticky=0 before the next edge; in_ready=1.
